// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative IEEE-754 single-precision divider, one quotient bit per cycle.
// Round-to-zero by default; defining FP_DIV_RNE_EN selects round-to-nearest-even.
module fp_div_seq #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        dz
);
  typedef enum logic [2:0] {IDLE, CHECK, DIV, PACK, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] a_r, b_r;
  logic sign;
  logic signed [9:0] e;
  logic [24:0] rem;
  logic [23:0] dvs;
  logic [ITER-1:0] q;
  logic [4:0] cnt;
  logic [7:0] ea, eb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, sg, spec_dz;
  logic [31:0] spec_res, pack_res;
  logic ge;
  logic [23:0] diff;
  logic [22:0] mant;
  logic [23:0] fr;
  logic signed [9:0] en, er;
  logic up;
  assign ea = a_r[30:23];
  assign eb = b_r[30:23];
  assign sg = a_r[31] ^ b_r[31];
  assign a_nan = (&ea) & (|a_r[22:0]);
  assign b_nan = (&eb) & (|b_r[22:0]);
  assign a_inf = (&ea) & ~(|a_r[22:0]);
  assign b_inf = (&eb) & ~(|b_r[22:0]);
  assign a_zero = ea == 8'd0;
  assign b_zero = eb == 8'd0;
  assign special = (&ea) | (&eb) | a_zero | b_zero;
  assign spec_res = (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) ? 32'h7F800001 :
                    (a_inf | b_zero) ? {sg, 8'hFF, 23'd0} : {sg, 31'd0};
  assign spec_dz = b_zero & ~a_zero & ~(&ea);
  assign ge = rem >= {1'b0, dvs};
  assign diff = rem[23:0] - dvs;
  // A leading zero quotient bit means a/b < 1: normalise by one position.
  assign mant = q[ITER-1] ? q[ITER-2:ITER-24] : q[ITER-3:ITER-25];
  assign en = q[ITER-1] ? e : e - 10'sd1;
`ifdef FP_DIV_RNE_EN
  logic guard, sticky;
  assign guard = q[ITER-1] ? q[ITER-25] : q[ITER-26];
  assign sticky = (q[ITER-1] & q[ITER-26]) | (|rem);
  assign up = guard & (sticky | mant[0]);
`else
  assign up = 1'b0;
`endif
  assign fr = {1'b0, mant} + {23'd0, up};
  assign er = fr[23] ? en + 10'sd1 : en;
  assign pack_res = er >= 10'sd255 ? {sign, 8'hFF, 23'd0} :
                    er <= 10'sd0 ? {sign, 31'd0} : {sign, er[7:0], fr[22:0]};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CHECK : IDLE;
      CHECK:   state_nx = special ? DONE : DIV;
      DIV:     state_nx = cnt == 5'(ITER-1) ? PACK : DIV;
      PACK:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      sign <= 1'b0;
      e <= '0;
      rem <= '0;
      dvs <= '0;
      q <= '0;
      cnt <= '0;
      result <= '0;
      dz <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b;
      end
      if (state == CHECK) begin
        sign <= sg;
        e <= $signed({2'b00, ea} - {2'b00, eb} + 10'd127);
        rem <= {2'b01, a_r[22:0]};
        dvs <= {1'b1, b_r[22:0]};
        q <= '0;
        cnt <= '0;
        if (special) begin
          result <= spec_res;
          dz <= spec_dz;
        end
      end
      if (state == DIV) begin
        rem <= ge ? {diff, 1'b0} : {rem[23:0], 1'b0};
        q <= {q[ITER-2:0], ge};
        cnt <= cnt + 5'd1;
      end
      if (state == PACK) begin
        result <= pack_res;
        dz <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed scoreboard bench for the sequential fp divider.
module tb_fp_div_seq;
  logic clk = 1'b0, rst, start;
  logic [31:0] a, b, result;
  logic busy, done, dz;
  int checks = 0, errs = 0, cyc = 0, done_cnt = 0, dc0;
  typedef struct { logic [31:0] r; logic dz; int n; int lat; string tag; } exp_t;
  exp_t sb[$];
`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  fp_div_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                  .busy(busy), .done(done), .result(result), .dz(dz));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_res"}, result, e.r);
        chk({e.tag, "_dz"}, 32'(dz), 32'(e.dz));
        chk({e.tag, "_lat"}, 32'(cyc - e.n), 32'(e.lat));
        chk({e.tag, "_busy"}, 32'(busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                       input logic d, input int lat, input string tag, input bit track);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    if (track) sb.push_back('{r, d, cyc, lat, tag});
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    rst = 1'b0;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "six_by_two", 1); drain();
    issue(32'h3F800000, 32'h40400000, THIRD, 1'b0, 29, "third", 1); drain();
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2, "one_by_zero", 1); drain();
    @(negedge clk);
    chk("dz_hold", 32'(dz), 32'd1);
    issue(32'h00000000, 32'h00000000, 32'h7F800001, 1'b0, 2, "zero_by_zero", 1); drain();
    issue(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 29, "neg_div", 1); drain();
    issue(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 29, "overflow", 1); drain();
    issue(32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 29, "underflow", 1); drain();
    issue(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 2, "subnormal", 1); drain();
    issue(32'h7F800001, 32'h00000000, 32'h7F800001, 1'b0, 2, "nan_by_zero", 1); drain();
    issue(32'h7F800000, 32'hFF800000, 32'h7F800001, 1'b0, 2, "inf_by_inf", 1); drain();
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 2, "inf_by_fin", 1); drain();
    issue(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2, "neg_by_zero", 1); drain();
    issue(32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 2, "fin_by_inf", 1); drain();
    issue(32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 2, "negzero", 1); drain();
    issue(32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0, 29, "three_by_1p5", 1); drain();
    issue(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, 29, "half", 1); drain();
    // start during the DONE cycle must be dropped
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "done_start", 1);
    begin
      int k = 0;
      while (done !== 1'b1 && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    chk("wait_done", 32'(done), 32'd1);
    a = 32'h3F800000;
    b = 32'h3F800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    // a second start while busy is ignored
    dc0 = done_cnt;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "busy_start", 1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h00000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    chk("one_done", 32'(done_cnt - dc0), 32'd1);
    // reset mid-operation aborts silently
    dc0 = done_cnt;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, "aborted", 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    issue(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 29, "after_abort", 1); drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
